particle_loader: RTL
====================

// Module: particle_loader
// PURPOSE
//  Host-side transmitter for the simulator's particle-initialisation port (data_in_ready / data_in[255:0]).
//  Accepts one particle per valid/ready beat: 96-bit position, 96-bit velocity, cell id.
//  Assigns each particle the next free slot in its cell's P/V BRAM pair and packs it into the 256-bit init word.
//  After the last particle it emits the padding beats the simulator's init counter needs to raise mem_set.
// PARAMETERS
//  N_CELL       27   number of cells; valid cell ids 0..N_CELL-1
//  N_PARTICLES  300  particles per load; the simulator's N_PARTICLES must be set to the same value
//  CELL_DEPTH   512  slots per cell BRAM; address width fixed at 9 bits
//  N_PAD        3    padding beats sent after the last particle
// PORTS
//  clk          in   1    simulator core clock (slow clk domain); every output is registered on its rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  start        in   1    1-cycle pulse; begins a load (honoured in IDLE and DONE only)
//  s_valid      in   1    host particle valid
//  s_ready      out  1    loader can accept a particle this cycle
//  s_pos        in   96   particle position {z,y,x}, 32 bits each
//  s_vel        in   96   particle velocity {z,y,x}, 32 bits each
//  s_cell       in   8    destination cell id
//  data_in_ready out 1    beat strobe to simulator; high exactly 1 cycle per word
//  data_in      out  256  packed init word
//  busy         out  1    high in LOAD and PAD
//  done         out  1    high in DONE until next start
//  loaded       out  10   particles accepted in this load (includes dropped ones)
//  err_cell     out  1    sticky: a particle arrived with s_cell >= N_CELL
//  err_full     out  1    sticky: a particle arrived for a cell whose slots were all used
// BEHAVIOUR
//  Reset (reset_n=0, async, any state): state=IDLE.
//   Outputs: s_ready=0, data_in_ready=0, data_in=0, busy=0, done=0, loaded=0, err_*=0.
//   All N_CELL slot counters are cleared to 0.
//  Word format: [95:0]=pos, [191:96]=vel, [199:192]=cell, [208:200]=slot addr, [255:209]=0.
//  States:
//   IDLE -start-> LOAD: clears slot counters, loaded and err_*.
//   LOAD: s_ready = (loaded < N_PARTICLES). A beat is taken when s_valid & s_ready.
//    Good particle (cell < N_CELL and slot counter[cell] < CELL_DEPTH): next cycle data_in = packed word,
//    data_in_ready = 1, slot counter[cell] += 1. Latency is 1 cycle, so back-to-back beats give back-to-back words.
//    Bad cell id: err_cell set, no strobe, no counter change, loaded still increments.
//    Full cell: err_full set, no strobe, no counter change, loaded still increments.
//    When the beat that makes loaded == N_PARTICLES is taken: s_ready drops the same cycle (combinational on loaded),
//    and the state moves to PAD.
//   PAD: N_PAD consecutive cycles of data_in_ready = 1.
//    Each word has cell = 8'hFF and every other field 0, so no cell BRAM matches it.
//    Then the state moves to DONE.
//   DONE: done = 1, s_ready = 0. start -> LOAD (reload: counters cleared).
//  data_in holds its last value when data_in_ready = 0. The simulator samples data_in only when the strobe is high.
//  start is ignored in LOAD and PAD; s_valid is ignored outside LOAD.
//  Dropped particles still count toward N_PARTICLES. The simulator's beat count is then short; err_* flags it to the host.
//  Slot counters are 10 bits, saturating at CELL_DEPTH; the emitted addr is counter[8:0] (never wraps).
//  reset_n deasserted mid-LOAD: the partial load is abandoned; the host must also reset the simulator.
// TESTING
//  1. N_PARTICLES=4, cells 0,0,5,0 back-to-back -> addrs 0,1,0,2 on 4 consecutive strobes.
//     Then 3 pad words (cell 8'hFF); total 7 strobes; done=1 the next cycle.
//  2. s_valid toggled 1,0,1 with cell 2 -> strobes only 1 cycle after each accepted beat; data_in holds between.
//  3. s_cell=27 (N_CELL=27) -> err_cell=1, no strobe, loaded increments; later cell-1 particle gets addr 0.
//  4. CELL_DEPTH=4 override, 5 particles to cell 3 -> addrs 0..3 emitted, 5th dropped, err_full=1.
//  5. reset_n pulsed low mid-LOAD after 2 beats -> all outputs 0 immediately; after start, cell-0 addr restarts at 0.
//  6. start during PAD is ignored; start in DONE -> LOAD, loaded=0, err_* cleared, first addr per cell 0.

Source files
------------

// File: rtl/particle_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : particle_loader_if
// Brief    : Host particle stream plus simulator init-word port.
// Revision : 1.0
// ============================================================================
interface particle_loader_if;
    logic         s_valid;
    logic         s_ready;
    logic [95:0]  s_pos;
    logic [95:0]  s_vel;
    logic [7:0]   s_cell;
    logic         data_in_ready;
    logic [255:0] data_in;

    // Host / testbench side
    modport master (
        output s_valid, s_pos, s_vel, s_cell,
        input  s_ready, data_in_ready, data_in
    );

    // Loader side
    modport slave (
        input  s_valid, s_pos, s_vel, s_cell,
        output s_ready, data_in_ready, data_in
    );
endinterface
`default_nettype wire

// File: rtl/particle_loader.sv
`default_nettype none
// ============================================================================
// Module   : particle_loader
// Brief    : Packs host particles into simulator init words, with per-cell slots.
// Revision : 1.0
// ============================================================================
module particle_loader #(
    parameter int N_CELL      = 27,
    parameter int N_PARTICLES = 300,
    parameter int CELL_DEPTH  = 512,
    parameter int N_PAD       = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    particle_loader_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic [9:0]       loaded,
    output logic             err_cell,
    output logic             err_full
);
    localparam int IDX_W = (N_CELL > 1) ? $clog2(N_CELL) : 1;
    localparam int PAD_W = (N_PAD > 0) ? $clog2(N_PAD + 1) : 1;
    localparam logic [7:0]       C_N_CELL = 8'(N_CELL);
    localparam logic [9:0]       C_N_PART = 10'(N_PARTICLES);
    localparam logic [9:0]       C_DEPTH  = 10'(CELL_DEPTH);
    localparam logic [PAD_W-1:0] C_N_PAD  = PAD_W'(N_PAD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [9:0]         r_slot [N_CELL];
    logic [9:0]         r_loaded;
    logic [PAD_W-1:0]   r_pad_cnt;
    logic               r_strobe;
    logic [255:0]       r_data;
    logic               r_err_cell;
    logic               r_err_full;

    logic               w_ready;
    logic               w_take;
    logic               w_cell_ok;
    logic [IDX_W-1:0]   w_idx;
    logic [9:0]         w_slot;
    logic               w_full;
    logic               w_start_ok;

    assign w_ready    = (r_state == ST_LOAD) && (r_loaded < C_N_PART);
    assign w_take     = bus.s_valid && w_ready;
    assign w_cell_ok  = bus.s_cell < C_N_CELL;
    // Out-of-range ids are steered to slot 0 only to keep the lookup in bounds
    assign w_idx      = w_cell_ok ? bus.s_cell[IDX_W-1:0] : '0;
    assign w_slot     = r_slot[w_idx];
    assign w_full     = w_slot >= C_DEPTH;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LOAD;
            ST_LOAD: if (w_take && (r_loaded == C_N_PART - 10'd1)) w_next = ST_PAD;
            ST_PAD:  if (r_pad_cnt == C_N_PAD) w_next = ST_DONE;
            ST_DONE: if (start) w_next = ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CELL; i++) r_slot[i] <= '0;
            r_loaded   <= '0;
            r_pad_cnt  <= '0;
            r_strobe   <= 1'b0;
            r_data     <= '0;
            r_err_cell <= 1'b0;
            r_err_full <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_start_ok) begin
                for (int i = 0; i < N_CELL; i++) r_slot[i] <= '0;
                r_loaded   <= '0;
                r_pad_cnt  <= '0;
                r_err_cell <= 1'b0;
                r_err_full <= 1'b0;
            end else if (w_take) begin
                r_loaded <= r_loaded + 10'd1;
                if (!w_cell_ok) begin
                    r_err_cell <= 1'b1;
                end else if (w_full) begin
                    r_err_full <= 1'b1;
                end else begin
                    r_strobe      <= 1'b1;
                    r_data        <= {47'd0, w_slot[8:0], bus.s_cell, bus.s_vel, bus.s_pos};
                    r_slot[w_idx] <= w_slot + 10'd1;
                end
            end else if ((r_state == ST_PAD) && (r_pad_cnt != C_N_PAD)) begin
                // Cell 0xFF matches no BRAM; these beats only advance the init counter
                r_strobe  <= 1'b1;
                r_data    <= {47'd0, 9'd0, 8'hFF, 192'd0};
                r_pad_cnt <= r_pad_cnt + PAD_W'(1);
            end
        end
    end

    assign bus.s_ready       = w_ready;
    assign bus.data_in_ready = r_strobe;
    assign bus.data_in       = r_data;
    assign busy              = (r_state == ST_LOAD) || (r_state == ST_PAD);
    assign done              = (r_state == ST_DONE);
    assign loaded            = r_loaded;
    assign err_cell          = r_err_cell;
    assign err_full          = r_err_full;
endmodule
`default_nettype wire
